md_issue_ctrl: RTL

- Sequencing controller for the multiply/divide unit in the pipelined CPU. Sits between the E stage and the mult/div unit.
- Converts the E-stage md instruction class into START/OP/WE_HI/WE_LO strobes.
- Tracks the unit's fixed latency with its own countdown and stalls D while any md-class instruction would collide with a running operation.
- Gates issue on exception flush and flags any disagreement with the unit's BUSY.

---
 rtl/md_issue_ctrl_pkg.sv | 47 ++++
 rtl/md_latency_counter.sv | 38 +++
 rtl/md_issue_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the mult/div issue controller.
// Holds E-stage md class codes, unit opcodes and default latencies.
package md_issue_ctrl_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam logic [1:0] OP_MULTU = 2'd0;
   localparam logic [1:0] OP_MULT  = 2'd1;
   localparam logic [1:0] OP_DIVU  = 2'd2;
   localparam logic [1:0] OP_DIV   = 2'd3;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam int CNT_W_DEF    = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // True for the classes that occupy the unit for a full latency.
   function automatic logic md_is_start(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

   // Class code to unit opcode; non-start classes map to 0.
   function automatic logic [1:0] md_unit_op(input logic [2:0] op);
      logic [1:0] r;
      r = OP_MULTU;
      case (op)
         MD_MULT:  r = OP_MULT;
         MD_MULTU: r = OP_MULTU;
         MD_DIV:   r = OP_DIV;
         MD_DIVU:  r = OP_DIVU;
         default:  r = OP_MULTU;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter with zero flag.
// Saturates at zero; load has priority over decrement.
module md_latency_counter #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, else decrement toward zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Mult/div issue sequencer between E stage and the mult/div unit.
// Issues strobes, shadows unit latency, stalls D, flags BUSY mismatch.
module md_issue_ctrl
   import md_issue_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       E_VALID,
   input  logic [2:0] E_MD_OP,
   input  logic       FLUSH,
   input  logic       D_USE_MD,
   input  logic       MD_BUSY,
   output logic       MD_START,
   output logic [1:0] MD_OP,
   output logic       MD_WE_HI,
   output logic       MD_WE_LO,
   output logic       STALL_D,
   output logic       ERR
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

   md_state_e        state_q;
   md_state_e        state_d;
   logic             err_q;
   logic             err_d;
   logic             run;
   logic             issue_ok;
   logic             start;
   logic             is_div;
   logic             is_md;
   logic             hold_err;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_ld_val;

   assign run      = (state_q == ST_RUN);
   assign issue_ok = ~RESET & E_VALID & ~FLUSH & ~run;
   assign start    = issue_ok & md_is_start(E_MD_OP);
   assign is_div   = (E_MD_OP == MD_DIV) || (E_MD_OP == MD_DIVU);
   assign is_md    = md_is_start(E_MD_OP) ||
                     (E_MD_OP == MD_MTHI) || (E_MD_OP == MD_MTLO);

   // An unflushed md op sitting in E during RUN means upstream
   // stall logic let it through; it is dropped and reported.
   assign hold_err = run & E_VALID & ~FLUSH & is_md;

   assign cnt_ld_val = is_div ? DIV_LD : MULT_LD;

   assign MD_START = start;
   assign MD_OP    = start ? md_unit_op(E_MD_OP) : OP_MULTU;
   assign MD_WE_HI = issue_ok & (E_MD_OP == MD_MTHI);
   assign MD_WE_LO = issue_ok & (E_MD_OP == MD_MTLO);
   assign STALL_D  = ~RESET & D_USE_MD & (start | run | MD_BUSY);
   assign ERR      = err_q;

   md_latency_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk_i      (CLK),
      .rst_i      (RESET),
      .load_i     (cnt_load),
      .load_val_i (cnt_ld_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Next state: enter RUN on start, leave when countdown hits zero.
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               cnt_load = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky error: tracker vs unit BUSY, or md op held in E during RUN.
   always_comb begin
      err_d = err_q | (run != MD_BUSY) | hold_err;
   end

   // State and error registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

endmodule
